leiwand_rv32_spi_bus_bridge: RTL
================================

// Module: leiwand_rv32_spi_bus_bridge
// PURPOSE
// - SPI mode-0 responder (target) that lets an external SPI host read/write the SoC memory bus: the far end of the
//   SPI link the flash controller drives as initiator. Decodes host commands and acts as a second bus initiator
//   (valid/ready/wen handshake, same as the CPU). Sits beside the CPU at SoC top behind a bus arbiter.
// PARAMETERS
// - ADDR_HI   8'h00         bits [31:24] of every bus address (host supplies a 24-bit address)
// - RD_CMD    8'h0B         read opcode (8 dummy clocks follow the address)
// - WR_CMD    8'h02         write opcode
// - ERR_WORD  32'hDEADBEEF  word shifted out when read data is not ready in time
// PORTS
// - clk          in   1      system clock; must be >= 8x spi_sclk
// - resetn       in   1      synchronous, active-low reset
// - spi_csn      in   1      chip select, active low, asynchronous to clk
// - spi_sclk     in   1      SPI clock, idle low, asynchronous to clk
// - spi_mosi     in   1      host->bridge data, MSB first
// - spi_miso     out  1      bridge->host data, MSB first
// - spi_miso_oe  out  1      MISO output enable (1 only while csn low)
// - mem_valid    out  1      bus request
// - mem_ready    in   1      bus completion strobe
// - mem_addr     out  32     word address {ADDR_HI, addr24[23:2], 2'b00}
// - mem_wdata    out  32     write data
// - mem_rdata    in   32     read data, valid when mem_ready
// - mem_wen      out  4      4'b1111 for writes, 4'b0000 for reads
// - err          out  1      sticky: write overrun or late read data; cleared at csn falling edge
// BEHAVIOUR
// - Reset: all outputs 0; SPI FSM IDLE; bus FSM B_IDLE; read buffer invalid.
// - csn/sclk/mosi pass through 2-FF synchronisers; edges detected on synced sclk. Sample mosi on rising edge,
//   update miso on falling edge. Pin-to-internal-event latency: 3 clk.
// - SPI FSM: IDLE -(csn fall)-> CMD (8 bits) -> ADDR (24 bits) -> read: DUMMY (8 bits) -> RDATA;
//   write: WDATA; unknown opcode -> IGNORE until csn high. csn high in any state -> IDLE within 3 clk.
// - Address: low 2 bits of addr24 ignored; increments by 4 after each data word; bits [23:2] wrap 0x3FFFFF->0
//   without touching ADDR_HI.
// - Read: bus read issued on the clk after the last address bit. Read buffer receives the data. At the falling
//   edge ending DUMMY, and after every 32nd RDATA bit, the shift register loads the buffer (or ERR_WORD and set
//   err if buffer invalid), bit 31 drives miso, and the next sequential read is issued immediately (prefetch).
// - Write: each completed 32-bit word is latched and a bus write is issued on the next clk. If the previous write
//   is still pending when the next word completes: new word dropped, address still advances, err set.
// - Bus FSM: B_IDLE -> B_RD/B_WR (mem_valid=1) -> B_IDLE on the clk mem_ready is seen. mem_valid, mem_addr,
//   mem_wdata and mem_wen are stable while valid; mem_valid drops the clk after ready. No timeout.
// - csn rising mid-word: partial word discarded; an in-flight bus transaction completes normally; prefetched
//   read data discarded. A new csn fall during an in-flight transaction waits (CMD still shifts) for completion
//   before issuing.
// - spi_miso = 0 outside RDATA; spi_miso_oe = ~csn_sync.
// - resetn low mid-transfer: immediate return to reset state; mem_valid dropped (bus peers tolerate it at reset).
// STRUCTURE
// - Opcodes and XLEN belong in leiwand_rv32_constants.v (`SPI_BR_RD_CMD, `SPI_BR_WR_CMD).
// - Sub-module leiwand_rv32_spi_sync: 2-FF synchronisers for csn/sclk/mosi, sclk rise/fall and csn fall/rise
//   strobes. Top holds SPI FSM, bit counter, shift registers, address counter and bus FSM.
// TESTING
// - Write 02 00 10 00 + 11223344 -> one bus write addr 0x00001000, wdata 0x11223344, wen 4'hF; err=0.
// - Read 0B 00 10 00 + dummy, mem returns 0xCAFEF00D at 0x1000 and 0x01020304 at 0x1004 (ready in 2 clk)
//   -> miso streams CAFEF00D then 01020304; reads issued at 0x1000, 0x1004, 0x1008.
// - Read with mem_ready delayed 200 clk at SCLK=clk/8 -> first word DEADBEEF, err=1; next csn fall clears err.
// - Write two words while mem_ready held low 400 clk -> first word written at 0x00001000, second dropped,
//   err=1; next transfer addresses from its own command.
// - Write with ADDR_HI=8'h20 to 0xFFFFFC, two words -> writes at 0x20FFFFFC then 0x20000000.
// - csn high after 20 data bits of a write -> no bus write; opcode 0x9F -> no bus traffic, miso stays 0.

Source files
------------

// File: rtl/leiwand_rv32_spi_bus_bridge_pkg.sv
// Shared constants and state types for the SPI-to-memory-bus bridge.
// Opcodes, error word and bus address helper live here so the bridge and its users agree.
package leiwand_rv32_spi_bus_bridge_pkg;

  localparam int XLEN = 32;

  localparam logic [7:0]      SPI_BR_RD_CMD   = 8'h0B;
  localparam logic [7:0]      SPI_BR_WR_CMD   = 8'h02;
  localparam logic [XLEN-1:0] SPI_BR_ERR_WORD = 32'hDEADBEEF;
  localparam logic [3:0]      WEN_WORD        = 4'b1111;
  localparam logic [3:0]      WEN_READ        = 4'b0000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_DUMMY,
    S_RDATA,
    S_WDATA,
    S_IGNORE
  } spi_state_t;

  typedef enum logic [1:0] {
    B_IDLE,
    B_RD,
    B_WR
  } bus_state_t;

  // Word index within the 24-bit window, placed under the fixed high byte.
  function automatic logic [XLEN-1:0] word_addr(input logic [7:0] hi, input logic [21:0] idx);
    return {hi, idx, 2'b00};
  endfunction

endpackage

// File: rtl/leiwand_rv32_spi_sync.sv
// Two-flop synchronisers for the SPI pins plus single-cycle edge strobes on the synced
// sclk and csn; pin-to-strobe latency is two clk, acted on at the third.
module leiwand_rv32_spi_sync
  import leiwand_rv32_spi_bus_bridge_pkg::*;
(
  input  logic clk,
  input  logic resetn,
  input  logic csn,
  input  logic sclk,
  input  logic mosi,
  output logic csn_sync,
  output logic mosi_sync,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic csn_fall,
  output logic csn_rise
);

  logic [2:0] csn_q;
  logic [2:0] sclk_q;
  logic [1:0] mosi_q;

  // csn resets to the deselected level so reset never looks like a chip-select edge.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      csn_q  <= 3'b111;
      sclk_q <= 3'b000;
      mosi_q <= 2'b00;
    end else begin
      csn_q  <= {csn_q[1:0], csn};
      sclk_q <= {sclk_q[1:0], sclk};
      mosi_q <= {mosi_q[0], mosi};
    end
  end

  assign csn_sync  = csn_q[1];
  assign mosi_sync = mosi_q[1];
  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall = ~sclk_q[1] & sclk_q[2];
  assign csn_fall  = ~csn_q[1] & csn_q[2];
  assign csn_rise  = csn_q[1] & ~csn_q[2];

endmodule

// File: rtl/leiwand_rv32_spi_bus_bridge.sv
// SPI mode-0 target that turns host read/write commands into word transactions on the
// SoC valid/ready memory bus, with one-word read prefetch and single-entry write buffering.
module leiwand_rv32_spi_bus_bridge
  import leiwand_rv32_spi_bus_bridge_pkg::*;
#(
  parameter logic [7:0]      ADDR_HI  = 8'h00,
  parameter logic [7:0]      RD_CMD   = SPI_BR_RD_CMD,
  parameter logic [7:0]      WR_CMD   = SPI_BR_WR_CMD,
  parameter logic [XLEN-1:0] ERR_WORD = SPI_BR_ERR_WORD
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            spi_csn,
  input  logic            spi_sclk,
  input  logic            spi_mosi,
  output logic            spi_miso,
  output logic            spi_miso_oe,
  output logic            mem_valid,
  input  logic            mem_ready,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  output logic [3:0]      mem_wen,
  output logic            err
);

  logic csn_sync, mosi_sync, sclk_rise, sclk_fall, csn_fall, csn_rise;

  leiwand_rv32_spi_sync u_sync (
    .clk       (clk),
    .resetn    (resetn),
    .csn       (spi_csn),
    .sclk      (spi_sclk),
    .mosi      (spi_mosi),
    .csn_sync  (csn_sync),
    .mosi_sync (mosi_sync),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .csn_fall  (csn_fall),
    .csn_rise  (csn_rise)
  );

  spi_state_t spi_state, spi_next;
  bus_state_t bus_state, bus_next;

  logic [5:0]      bit_cnt;
  logic [XLEN-1:0] shift_in;
  logic [XLEN-1:0] shift_nxt;
  logic [XLEN-1:0] shift_out;
  logic [21:0]     addr;
  logic            is_read;
  logic            rd_req;
  logic            wr_req;
  logic [21:0]     wr_addr;
  logic [XLEN-1:0] wr_data;
  logic [XLEN-1:0] rbuf;
  logic            rbuf_valid;
  logic            launch_rd, launch_wr;
  logic            active, load_now, wr_busy, rd_session;

  assign shift_nxt  = {shift_in[XLEN-2:0], mosi_sync};
  assign active     = !csn_sync && !csn_fall;
  assign wr_busy    = wr_req || (bus_state == B_WR);
  assign rd_session = (spi_state == S_DUMMY) || (spi_state == S_RDATA);
  assign load_now   = active && sclk_fall &&
                      (((spi_state == S_DUMMY) && (bit_cnt == 6'd8)) ||
                       ((spi_state == S_RDATA) && (bit_cnt == 6'd32)));

  // NOTE: every variable gets its default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    spi_next = spi_state;
    if (csn_sync) begin
      spi_next = S_IDLE;
    end else if (csn_fall) begin
      spi_next = S_CMD;
    end else begin
      unique case (spi_state)
        S_CMD:
          if (sclk_rise && bit_cnt == 6'd7)
            spi_next = (shift_nxt[7:0] == RD_CMD || shift_nxt[7:0] == WR_CMD) ? S_ADDR : S_IGNORE;
        S_ADDR:
          if (sclk_rise && bit_cnt == 6'd23)
            spi_next = is_read ? S_DUMMY : S_WDATA;
        S_DUMMY:
          if (load_now) spi_next = S_RDATA;
        default: ;
      endcase
    end
  end

  // Writes win over reads; in practice both are never pending from the same transfer.
  always_comb begin
    bus_next  = bus_state;
    launch_rd = 1'b0;
    launch_wr = 1'b0;
    unique case (bus_state)
      B_IDLE:
        if (wr_req) begin
          bus_next  = B_WR;
          launch_wr = 1'b1;
        end else if (rd_req) begin
          bus_next  = B_RD;
          launch_rd = 1'b1;
        end
      B_RD, B_WR:
        if (mem_ready) bus_next = B_IDLE;
      default: bus_next = B_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so later statements in this block
  // override earlier ones for the same register within a cycle without ordering hazards.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      spi_state  <= S_IDLE;
      bus_state  <= B_IDLE;
      bit_cnt    <= '0;
      shift_in   <= '0;
      shift_out  <= '0;
      addr       <= '0;
      is_read    <= 1'b0;
      rd_req     <= 1'b0;
      wr_req     <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      rbuf       <= '0;
      rbuf_valid <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wen    <= WEN_READ;
      err        <= 1'b0;
    end else begin
      spi_state <= spi_next;
      bus_state <= bus_next;

      if (launch_wr) begin
        wr_req    <= 1'b0;
        mem_addr  <= word_addr(ADDR_HI, wr_addr);
        mem_wdata <= wr_data;
        mem_wen   <= WEN_WORD;
      end
      if (launch_rd) begin
        rd_req   <= 1'b0;
        mem_addr <= word_addr(ADDR_HI, addr);
        mem_wen  <= WEN_READ;
        addr     <= addr + 22'd1;
      end

      if (csn_sync) begin
        bit_cnt <= '0;
        if (csn_rise) begin
          rd_req     <= 1'b0;
          rbuf_valid <= 1'b0;
        end
      end else if (csn_fall) begin
        bit_cnt <= '0;
        err     <= 1'b0;
      end else begin
        unique case (spi_state)
          S_CMD:
            if (sclk_rise) begin
              shift_in <= shift_nxt;
              bit_cnt  <= (bit_cnt == 6'd7) ? 6'd0 : bit_cnt + 6'd1;
              if (bit_cnt == 6'd7) is_read <= (shift_nxt[7:0] == RD_CMD);
            end
          S_ADDR:
            if (sclk_rise) begin
              shift_in <= shift_nxt;
              if (bit_cnt == 6'd23) begin
                bit_cnt <= '0;
                addr    <= shift_nxt[23:2];
                if (is_read) rd_req <= 1'b1;
              end else begin
                bit_cnt <= bit_cnt + 6'd1;
              end
            end
          S_DUMMY:
            if (sclk_rise) bit_cnt <= bit_cnt + 6'd1;
          S_RDATA:
            if (sclk_rise) bit_cnt <= bit_cnt + 6'd1;
            else if (sclk_fall && !load_now) shift_out <= {shift_out[XLEN-2:0], 1'b0};
          S_WDATA:
            if (sclk_rise) begin
              shift_in <= shift_nxt;
              if (bit_cnt == 6'd31) begin
                bit_cnt <= '0;
                addr    <= addr + 22'd1;
                if (wr_busy) begin
                  err <= 1'b1;
                end else begin
                  wr_req  <= 1'b1;
                  wr_addr <= addr;
                  wr_data <= shift_nxt;
                end
              end else begin
                bit_cnt <= bit_cnt + 6'd1;
              end
            end
          default: ;
        endcase
      end

      if (load_now) begin
        bit_cnt    <= '0;
        rbuf_valid <= 1'b0;
        rd_req     <= 1'b1;
        if (rbuf_valid) begin
          shift_out <= rbuf;
        end else begin
          shift_out <= ERR_WORD;
          err       <= 1'b1;
        end
      end

      // Reads that land after the host deselects are dropped rather than buffered.
      if (bus_state == B_RD && mem_ready && rd_session && !csn_sync) begin
        rbuf       <= mem_rdata;
        rbuf_valid <= 1'b1;
      end
    end
  end

  assign mem_valid   = (bus_state != B_IDLE);
  assign spi_miso    = (spi_state == S_RDATA) ? shift_out[XLEN-1] : 1'b0;
  assign spi_miso_oe = ~csn_sync;

endmodule
